// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable integer clock divider.
// A new ratio is taken over a valid/ready port and applied only at an output
// period boundary. Gating on/off also happens only at a period boundary, so
// div_clk never shows a runt or stretched pulse.
module clk_div_ctrl #(
    parameter int CNT_W     = 8,
    parameter int RATIO_RST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             busy,
    output logic             div_clk,
    output logic             div_tick
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    localparam logic [CNT_W-1:0] RATIO_INIT = CNT_W'(RATIO_RST);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] ratio, ratio_nxt;
    logic [CNT_W-1:0] pend_ratio, pend_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] half_nxt;
    logic             div_clk_nxt, div_tick_nxt;
    logic             xfer, legal, wrap, active_nxt;

    assign cfg_ready = (state != S_PEND);
    assign busy      = (state == S_PEND);
    assign xfer      = cfg_valid & cfg_ready;
    assign legal     = (cfg_ratio >= TWO);
    assign wrap      = (cnt == ratio - ONE);

    // Next-state, counter and ratio selection; the waveform is derived from
    // the next-state counter so div_clk/div_tick are clean registers.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        ratio_nxt = ratio;
        pend_nxt  = pend_ratio;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (en) state_nxt = S_RUN;
                if (xfer && legal) begin
                    if (en) begin
                        // First period after start still uses the old ratio.
                        state_nxt = S_PEND;
                        pend_nxt  = cfg_ratio;
                    end else begin
                        ratio_nxt = cfg_ratio;
                    end
                end
            end
            S_RUN: begin
                if (wrap) begin
                    cnt_nxt = '0;
                    if (!en) state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
                if (xfer && legal) begin
                    if (wrap && !en) begin
                        // Stopping anyway: nothing to wait for, apply directly.
                        ratio_nxt = cfg_ratio;
                    end else begin
                        state_nxt = S_PEND;
                        pend_nxt  = cfg_ratio;
                    end
                end
            end
            S_PEND: begin
                if (wrap) begin
                    cnt_nxt   = '0;
                    ratio_nxt = pend_ratio;
                    state_nxt = en ? S_RUN : S_IDLE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        active_nxt   = (state_nxt != S_IDLE);
        half_nxt     = ratio_nxt - (ratio_nxt >> 1);
        div_clk_nxt  = active_nxt && (cnt_nxt < half_nxt);
        div_tick_nxt = active_nxt && (cnt_nxt == '0);
    end

    // State, counter, ratio and registered outputs; async reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ratio      <= RATIO_INIT;
            pend_ratio <= RATIO_INIT;
            cnt        <= '0;
            div_clk    <= 1'b0;
            div_tick   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= state_nxt;
            ratio      <= ratio_nxt;
            pend_ratio <= pend_nxt;
            cnt        <= cnt_nxt;
            div_clk    <= div_clk_nxt;
            div_tick   <= div_tick_nxt;
            cfg_err    <= xfer && !legal;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl. Inputs change on the falling
// edge; outputs are checked on the falling edge after each rising edge.
module tb_clk_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_ratio;
    logic             cfg_ready;
    logic             cfg_err;
    logic             busy;
    logic             div_clk;
    logic             div_tick;

    int n_tests  = 0;
    int n_failed = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .RATIO_RST(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .div_clk   (div_clk),
        .div_tick  (div_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One source clock: rising edge, then settle to the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wave(input string tag, input logic c, input logic t);
        check({tag, ".div_clk"}, 32'(div_clk), 32'(c));
        check({tag, ".div_tick"}, 32'(div_tick), 32'(t));
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        wave("rst", 1'b0, 1'b0);
        check("rst.cfg_err", 32'(cfg_err), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.cfg_ready", 32'(cfg_ready), 32'd1);

        // 1: default ratio 2, first tick one cycle after en.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            wave("t1", (i % 2) == 0, (i % 2) == 0);
        end
        en = 1'b0;
        repeat (3) step();
        wave("t1.stop", 1'b0, 1'b0);

        // 2: ratio 5 programmed in IDLE, applied without PEND.
        cfg_valid = 1'b1;
        cfg_ratio = 8'd5;
        step();
        cfg_valid = 1'b0;
        check("t2.busy", 32'(busy), 32'd0);
        check("t2.cfg_ready", 32'(cfg_ready), 32'd1);
        check("t2.idle_clk", 32'(div_clk), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            wave("t2", (i % 5) < 3, (i % 5) == 0);
        end
        en = 1'b0;
        step();
        wave("t2.stop", 1'b0, 1'b0);
        step();
        wave("t2.idle", 1'b0, 1'b0);

        // 3: R=4, switch to 6 at cnt=1; change waits for the wrap.
        cfg_valid = 1'b1;
        cfg_ratio = 8'd4;
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        wave("t3.c0", 1'b1, 1'b1);
        step();
        wave("t3.c1", 1'b1, 1'b0);
        check("t3.ready_run", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ratio = 8'd6;
        step();
        cfg_valid = 1'b0;
        wave("t3.c2", 1'b0, 1'b0);
        check("t3.busy_c2", 32'(busy), 32'd1);
        check("t3.ready_c2", 32'(cfg_ready), 32'd0);
        step();
        wave("t3.c3", 1'b0, 1'b0);
        check("t3.busy_c3", 32'(busy), 32'd1);
        step();
        check("t3.busy_after", 32'(busy), 32'd0);
        check("t3.ready_after", 32'(cfg_ready), 32'd1);
        wave("t3.n0", 1'b1, 1'b1);
        for (int i = 1; i < 12; i++) begin
            step();
            wave("t3.r6", (i % 6) < 3, (i % 6) == 0);
        end

        // 4: illegal ratios 0 and 1 pulse cfg_err; R=6 keeps running.
        cfg_valid = 1'b1;
        cfg_ratio = 8'd0;
        step();
        check("t4.err0", 32'(cfg_err), 32'd1);
        wave("t4.c0", 1'b1, 1'b1);
        cfg_ratio = 8'd1;
        step();
        check("t4.err1", 32'(cfg_err), 32'd1);
        check("t4.busy", 32'(busy), 32'd0);
        wave("t4.c1", 1'b1, 1'b0);
        cfg_valid = 1'b0;
        step();
        check("t4.err_clr", 32'(cfg_err), 32'd0);
        wave("t4.c2", 1'b1, 1'b0);

        // 5: go to R=4, drop en at cnt=1; period completes then IDLE.
        cfg_valid = 1'b1;
        cfg_ratio = 8'd4;
        step();
        cfg_valid = 1'b0;
        check("t5.busy", 32'(busy), 32'd1);
        wave("t5.c3", 1'b0, 1'b0);
        step();
        wave("t5.c4", 1'b0, 1'b0);
        step();
        wave("t5.c5", 1'b0, 1'b0);
        step();
        wave("t5.n0", 1'b1, 1'b1);
        step();
        wave("t5.n1", 1'b1, 1'b0);
        en = 1'b0;
        step();
        wave("t5.n2", 1'b0, 1'b0);
        step();
        wave("t5.n3", 1'b0, 1'b0);
        step();
        wave("t5.idle0", 1'b0, 1'b0);
        step();
        wave("t5.idle1", 1'b0, 1'b0);
        check("t5.idle_busy", 32'(busy), 32'd0);
        en = 1'b1;
        step();
        wave("t5.restart", 1'b1, 1'b1);

        // 6: async reset during the high phase with R=7.
        en = 1'b0;
        repeat (4) step();
        wave("t6.idle", 1'b0, 1'b0);
        cfg_valid = 1'b1;
        cfg_ratio = 8'd7;
        step();
        cfg_valid = 1'b0;
        en = 1'b1;
        step();
        wave("t6.c0", 1'b1, 1'b1);
        step();
        wave("t6.c1", 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6.async_clk", 32'(div_clk), 32'd0);
        check("t6.async_busy", 32'(busy), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6.ready", 32'(cfg_ready), 32'd1);
        wave("t6.post", 1'b0, 1'b0);
        en = 1'b1;
        step();
        wave("t6.r2a", 1'b1, 1'b1);
        step();
        wave("t6.r2b", 1'b0, 1'b0);
        step();
        wave("t6.r2c", 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
